// File: rtl/tft_mem_arb.sv
// Arbiter between display burst reads and PPU framebuffer writes
// toward the SDRAM command port; reads win, writes never starve.
module tft_mem_arb #(
  parameter int AN     = 24,
  parameter int DN     = 16,
  parameter int BURST  = 8,
  parameter int STARVE = 4
) (
  input  logic          clkSYS,
  input  logic          n_reset,
  input  logic          req,
  input  logic [AN-1:0] req_addr,
  output logic          req_ack,
  output logic [DN-1:0] mem_data,
  output logic          mem_valid,
  input  logic          wr_req,
  input  logic [AN-1:0] wr_addr,
  input  logic [DN-1:0] wr_data,
  output logic          wr_ack,
  output logic [AN-1:0] sd_addr,
  output logic [DN-1:0] sd_wdata,
  output logic          sd_rd,
  output logic          sd_wr,
  input  logic          sd_ack,
  input  logic [DN-1:0] sd_data,
  input  logic          sd_valid,
  output logic          busy
);

  localparam int BW = $clog2(BURST) + 1;
  localparam int SW = $clog2(STARVE + 1);
  localparam logic [BW-1:0] LAST = BW'(BURST - 1);
  localparam logic [SW-1:0] STV  = SW'(STARVE);

  typedef enum logic [1:0] {
    IDLE,
    RD_CMD,
    RD_DATA,
    WR_CMD
  } state_t;

  state_t        state_q, state_d;
  logic [AN-1:0] addr_q, addr_d;
  logic [DN-1:0] wdata_q, wdata_d;
  logic [DN-1:0] mdata_q, mdata_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic          rack_q, rack_d;
  logic          wack_q, wack_d;
  logic          mval_q, mval_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [SW-1:0] starve_q, starve_d;

  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      mdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      rack_q   <= 1'b0;
      wack_q   <= 1'b0;
      mval_q   <= 1'b0;
      beat_q   <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mdata_q  <= mdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      rack_q   <= rack_d;
      wack_q   <= wack_d;
      mval_q   <= mval_d;
      beat_q   <= beat_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mdata_d  = mdata_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    rack_d   = 1'b0;
    wack_d   = 1'b0;
    mval_d   = 1'b0;
    beat_d   = beat_q;
    starve_d = starve_q;
    unique case (state_q)
      IDLE: begin
        if (req && (!wr_req || starve_q < STV)) begin
          addr_d  = req_addr;
          rd_d    = 1'b1;
          state_d = RD_CMD;
          // a pending write here implies starve_q < STV
          starve_d = wr_req ? starve_q + 1'b1 : '0;
        end else if (wr_req) begin
          addr_d   = wr_addr;
          wdata_d  = wr_data;
          wr_d     = 1'b1;
          state_d  = WR_CMD;
          starve_d = '0;
        end else begin
          starve_d = '0;
        end
      end
      RD_CMD: begin
        if (sd_ack) begin
          rd_d    = 1'b0;
          rack_d  = 1'b1;
          beat_d  = '0;
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (sd_valid) begin
          mdata_d = sd_data;
          mval_d  = 1'b1;
          beat_d  = beat_q + 1'b1;
          if (beat_q == LAST) state_d = IDLE;
        end
      end
      WR_CMD: begin
        if (sd_ack) begin
          wack_d  = 1'b1;
          wr_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ack   = rack_q;
  assign wr_ack    = wack_q;
  assign mem_data  = mdata_q;
  assign mem_valid = mval_q;
  assign sd_addr   = addr_q;
  assign sd_wdata  = wdata_q;
  assign sd_rd     = rd_q;
  assign sd_wr     = wr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_tft_mem_arb.sv
// Directed bench for tft_mem_arb: reads, writes, starvation,
// stray SDRAM strobes, mid-burst reset and gapped read data.
module tb_tft_mem_arb;

  logic        clkSYS = 1'b0;
  logic        n_reset;
  logic        req;
  logic [23:0] req_addr;
  logic        req_ack;
  logic [15:0] mem_data;
  logic        mem_valid;
  logic        wr_req;
  logic [23:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic [23:0] sd_addr;
  logic [15:0] sd_wdata;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [15:0] sd_data;
  logic        sd_valid;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  tft_mem_arb dut (
    .clkSYS   (clkSYS),
    .n_reset  (n_reset),
    .req      (req),
    .req_addr (req_addr),
    .req_ack  (req_ack),
    .mem_data (mem_data),
    .mem_valid(mem_valid),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .sd_addr  (sd_addr),
    .sd_wdata (sd_wdata),
    .sd_rd    (sd_rd),
    .sd_wr    (sd_wr),
    .sd_ack   (sd_ack),
    .sd_data  (sd_data),
    .sd_valid (sd_valid),
    .busy     (busy)
  );

  always #5 clkSYS = ~clkSYS;

  task automatic tick();
    @(posedge clkSYS);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic burst8(input logic [15:0] base, input string tag);
    for (int i = 0; i < 8; i++) begin
      sd_valid = 1'b1;
      sd_data  = base + 16'(i);
      tick();
      chk({tag, "_mval"}, 32'(mem_valid), 32'd1);
      chk({tag, "_mdata"}, 32'(mem_data), 32'(base) + 32'(i));
    end
    sd_valid = 1'b0;
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int  wacks;
    int  w;
    bool_t_dummy: begin end
    n_reset  = 1'b0;
    req      = 1'b1;
    req_addr = 24'h000100;
    wr_req   = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    sd_ack   = 1'b0;
    sd_data  = '0;
    sd_valid = 1'b0;
    #12;
    chk("rst_sd_rd", 32'(sd_rd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_outs", {req_ack, wr_ack, mem_valid, sd_wr}, 32'd0);
    chk("rst_addr", 32'(sd_addr), 32'd0);
    chk("rst_mdata", 32'(mem_data), 32'd0);

    // read: sd_rd held three cycles, then 8 back-to-back words
    #3 n_reset = 1'b1;
    tick();
    chk("rd_sd_rd1", 32'(sd_rd), 32'd1);
    chk("rd_addr", 32'(sd_addr), 32'h000100);
    chk("rd_busy", 32'(busy), 32'd1);
    tick();
    chk("rd_sd_rd2", 32'(sd_rd), 32'd1);
    tick();
    chk("rd_sd_rd3", 32'(sd_rd), 32'd1);
    chk("rd_noack", 32'(req_ack), 32'd0);
    sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    req    = 1'b0;
    chk("rd_sd_rd_off", 32'(sd_rd), 32'd0);
    chk("rd_req_ack", 32'(req_ack), 32'd1);
    sd_valid = 1'b1;
    sd_data  = 16'hA000;
    tick();
    chk("rd_req_ack_pulse", 32'(req_ack), 32'd0);
    chk("rd_w0", 32'(mem_data), 32'hA000);
    for (int i = 1; i < 8; i++) begin
      sd_data = 16'hA000 + 16'(i);
      tick();
      chk("rd_mval", 32'(mem_valid), 32'd1);
      chk("rd_word", 32'(mem_data), 32'hA000 + 32'(i));
      chk("rd_busy_mid", 32'(busy), 32'(i < 7));
    end
    sd_valid = 1'b0;
    tick();
    chk("rd_mval_end", 32'(mem_valid), 32'd0);

    // single write
    wr_req  = 1'b1;
    wr_addr = 24'h001234;
    wr_data = 16'hBEEF;
    tick();
    chk("wr_sd_wr", 32'(sd_wr), 32'd1);
    chk("wr_addr", 32'(sd_addr), 32'h001234);
    chk("wr_data", 32'(sd_wdata), 32'hBEEF);
    tick();
    chk("wr_hold", 32'(sd_wr), 32'd1);
    sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    wr_req = 1'b0;
    chk("wr_ack", 32'(wr_ack), 32'd1);
    chk("wr_sd_wr_off", 32'(sd_wr), 32'd0);
    tick();
    chk("wr_ack_pulse", 32'(wr_ack), 32'd0);
    chk("wr_idle", 32'(busy), 32'd0);

    // stray sd_valid / sd_ack while idle and during a write
    sd_valid = 1'b1;
    sd_ack   = 1'b1;
    sd_data  = 16'hDEAD;
    tick();
    chk("stray_idle_mval", 32'(mem_valid), 32'd0);
    chk("stray_idle_acks", {req_ack, wr_ack}, 32'd0);
    chk("stray_idle_busy", 32'(busy), 32'd0);
    sd_valid = 1'b0;
    sd_ack   = 1'b0;
    wr_req   = 1'b1;
    wr_addr  = 24'h002000;
    wr_data  = 16'h5555;
    tick();
    chk("stray_wr_cmd", 32'(sd_wr), 32'd1);
    sd_valid = 1'b1;
    tick();
    chk("stray_wr_mval", 32'(mem_valid), 32'd0);
    chk("stray_wr_hold", {sd_wr, busy}, 32'd3);
    sd_valid = 1'b0;
    sd_ack   = 1'b1;
    tick();
    sd_ack = 1'b0;
    wr_req = 1'b0;
    chk("stray_wr_ack", 32'(wr_ack), 32'd1);
    tick();

    // starvation: both held, expect R,R,R,R,W repeating
    req      = 1'b1;
    req_addr = 24'h000500;
    wr_req   = 1'b1;
    wr_addr  = 24'h000600;
    wr_data  = 16'h1111;
    wacks    = 0;
    for (int t = 0; t < 10; t++) begin
      w = 0;
      while (!(sd_rd || sd_wr) && w < 10) begin
        tick();
        w++;
      end
      chk("stv_grant_seen", 32'(sd_rd || sd_wr), 32'd1);
      chk("stv_order_wr", 32'(sd_wr), 32'(t == 4 || t == 9));
      chk("stv_addr", 32'(sd_addr),
          (t == 4 || t == 9) ? 32'h000600 : 32'h000500);
      sd_ack = 1'b1;
      tick();
      sd_ack = 1'b0;
      if (t == 4 || t == 9) begin
        chk("stv_wr_ack", 32'(wr_ack), 32'd1);
        if (wr_ack) wacks++;
      end else begin
        chk("stv_req_ack", 32'(req_ack), 32'd1);
        burst8(16'hC000, "stv");
      end
    end
    req    = 1'b0;
    wr_req = 1'b0;
    chk("stv_wack_count", 32'(wacks), 32'd2);
    tick();
    tick();

    // gapped read data, one word every 3 cycles
    req      = 1'b1;
    req_addr = 24'h000200;
    tick();
    chk("gap_sd_rd", 32'(sd_rd), 32'd1);
    sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    req    = 1'b0;
    chk("gap_req_ack", 32'(req_ack), 32'd1);
    for (int i = 0; i < 8; i++) begin
      sd_valid = 1'b1;
      sd_data  = 16'hB000 + 16'(i);
      tick();
      sd_valid = 1'b0;
      chk("gap_word", {15'd0, mem_valid, mem_data}, 32'h1B000 + 32'(i));
      tick();
      chk("gap_gap", 32'(mem_valid), 32'd0);
      chk("gap_busy", 32'(busy), 32'(i < 7));
      tick();
    end

    // reset after 3 of 8 words
    req      = 1'b1;
    req_addr = 24'h000300;
    tick();
    chk("mrst_sd_rd", 32'(sd_rd), 32'd1);
    sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    req    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sd_valid = 1'b1;
      sd_data  = 16'hD000 + 16'(i);
      tick();
      chk("mrst_pre", 32'(mem_valid), 32'd1);
    end
    #1 n_reset = 1'b0;
    #1;
    chk("mrst_outs", {mem_valid, sd_rd, busy}, 32'd0);
    chk("mrst_mdata", 32'(mem_data), 32'd0);
    #3 n_reset = 1'b1;
    for (int i = 3; i < 8; i++) begin
      sd_data = 16'hD000 + 16'(i);
      tick();
      chk("mrst_discard", {mem_valid, busy}, 32'd0);
    end
    sd_valid = 1'b0;
    req      = 1'b1;
    req_addr = 24'h000400;
    tick();
    chk("mrst_new_rd", 32'(sd_rd), 32'd1);
    chk("mrst_new_addr", 32'(sd_addr), 32'h000400);
    sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    req    = 1'b0;
    chk("mrst_new_ack", 32'(req_ack), 32'd1);
    burst8(16'hE000, "mrst_new");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
